// File: rtl/tex_v_stepper.sv
//------------------------------------------------------------------------------
// tex_v_stepper : per-column texture row generator feeding the wall texture ROM
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tex_v_stepper #(
    parameter int SCREEN_H    = 480,
    parameter int HEIGHT_BITS = 10,
    parameter int FRAC        = 12,
    parameter int TEX_BITS    = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [HEIGHT_BITS-1:0] height,
    input  logic                   side,
    input  logic [TEX_BITS-1:0]    col,
    input  logic                   adv,
    output logic                   ready,
    output logic                   wall_active,
    output logic                   tex_side,
    output logic [TEX_BITS-1:0]    tex_col,
    output logic [TEX_BITS-1:0]    tex_row,
    output logic                   done
);

    localparam int STEP_W  = TEX_BITS + FRAC + 1;
    localparam int DIV_CYC = STEP_W;
    localparam int MUL_CYC = HEIGHT_BITS;
    localparam int Y_W     = $clog2(SCREEN_H + 1);
    localparam int CW      = $clog2(DIV_CYC + 1);
    localparam int GW      = ((HEIGHT_BITS > Y_W) ? HEIGHT_BITS : Y_W) + 1;

    localparam logic [CW-1:0]     c_DIV_LAST = CW'(DIV_CYC - 1);
    localparam logic [CW-1:0]     c_MUL_LAST = CW'(MUL_CYC - 1);
    localparam logic [Y_W-1:0]    c_Y_LAST   = Y_W'(SCREEN_H - 1);
    localparam logic [GW-1:0]     c_SCREEN_H = GW'(SCREEN_H);
    localparam logic [STEP_W-1:0] c_DIVIDEND = {1'b1, {(STEP_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [HEIGHT_BITS-1:0] r_height;
    logic                   r_side;
    logic [TEX_BITS-1:0]    r_col;
    logic [STEP_W-1:0]      r_step;
    logic [HEIGHT_BITS-1:0] r_rem;
    logic [STEP_W-1:0]      r_acc;
    logic [GW-1:0]          r_skip;
    logic [CW-1:0]          r_cnt;
    logic [Y_W-1:0]         r_y;
    logic                   r_done;

    logic [GW-1:0]          w_in_ext;
    logic [GW-1:0]          w_skip;
    logic [GW-1:0]          w_h_ext;
    logic [GW-1:0]          w_top;
    logic [GW-1:0]          w_vis;
    logic [GW-1:0]          w_end;
    logic [GW-1:0]          w_y_ext;
    logic [HEIGHT_BITS:0]   w_trial;
    logic                   w_div_ge;
    logic [HEIGHT_BITS-1:0] w_rem_nxt;
    logic [STEP_W-1:0]      w_quo_nxt;
    logic [STEP_W-1:0]      w_mul_add;
    logic                   w_active;
    logic                   w_accept;
    logic                   w_last_adv;

    // Start-row clipping offset for walls taller than the screen.
    assign w_in_ext = {{(GW-HEIGHT_BITS){1'b0}}, height};
    assign w_skip   = (w_in_ext > c_SCREEN_H) ? ((w_in_ext - c_SCREEN_H) >> 1) : '0;

    assign w_h_ext  = {{(GW-HEIGHT_BITS){1'b0}}, r_height};
    assign w_top    = (w_h_ext < c_SCREEN_H) ? ((c_SCREEN_H - w_h_ext) >> 1) : '0;
    assign w_vis    = (w_h_ext < c_SCREEN_H) ? w_h_ext : c_SCREEN_H;
    assign w_end    = w_top + w_vis;
    assign w_y_ext  = {{(GW-Y_W){1'b0}}, r_y};

    // One restoring-division step: the dividend bits sit in r_step's MSBs and
    // are displaced by quotient bits as they are consumed.
    assign w_trial   = {r_rem, r_step[STEP_W-1]};
    assign w_div_ge  = (w_trial >= {1'b0, r_height});
    assign w_rem_nxt = w_div_ge ? (w_trial[HEIGHT_BITS-1:0] - r_height) : w_trial[HEIGHT_BITS-1:0];
    assign w_quo_nxt = {r_step[STEP_W-2:0], w_div_ge};

    assign w_mul_add = r_skip[HEIGHT_BITS-1] ? r_step : '0;

    assign w_active   = (r_state == S_RUN) && (r_height != '0) &&
                        (w_y_ext >= w_top) && (w_y_ext < w_end);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last_adv = (r_state == S_RUN) && adv && (r_y == c_Y_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == c_MUL_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_adv) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_height <= '0;
            r_side   <= 1'b0;
            r_col    <= '0;
            r_step   <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_skip   <= '0;
            r_cnt    <= '0;
            r_y      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_height <= height;
                        r_side   <= side;
                        r_col    <= col;
                        r_step   <= c_DIVIDEND;
                        r_rem    <= '0;
                        r_acc    <= '0;
                        r_skip   <= w_skip;
                        r_cnt    <= '0;
                        r_y      <= '0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    if (r_cnt == c_DIV_LAST) begin
                        r_cnt  <= '0;
                        r_step <= (r_height == '0) ? '0 : w_quo_nxt;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_step <= w_quo_nxt;
                    end
                end
                S_MUL: begin
                    r_acc  <= {r_acc[STEP_W-2:0], 1'b0} + w_mul_add;
                    r_skip <= r_skip << 1;
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_RUN: begin
                    if (adv) begin
                        r_y <= r_y + Y_W'(1);
                        if (w_active) begin
                            r_acc <= r_acc + r_step;
                        end
                        if (r_y == c_Y_LAST) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wall_active = w_active;
    assign tex_side    = r_side;
    assign tex_col     = r_col;
    assign tex_row     = w_active ? r_acc[FRAC+TEX_BITS-1:FRAC] : '0;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tex_v_stepper.sv
//------------------------------------------------------------------------------
// tb_tex_v_stepper : directed checks of tex_v_stepper row walk and robustness
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tex_v_stepper;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [9:0] height;
    logic       side;
    logic [5:0] col;
    logic       adv;
    logic       ready;
    logic       wall_active;
    logic       tex_side;
    logic [5:0] tex_col;
    logic [5:0] tex_row;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    tex_v_stepper dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .height      (height),
        .side        (side),
        .col         (col),
        .adv         (adv),
        .ready       (ready),
        .wall_active (wall_active),
        .tex_side    (tex_side),
        .tex_col     (tex_col),
        .tex_row     (tex_row),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        logic       s;
        logic [5:0] c;
    } cmd_t;

    typedef struct {
        int   h;
        int   y;
        logic act;
        int   row;
    } vec_t;

    cmd_t cmds [5];
    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int h, input logic s, input logic [5:0] c, input bit disturb);
        int   step, skip, top, vis, acc, exp_row;
        logic exp_act;
        step = (h == 0) ? 0 : (1 << 18) / h;
        skip = (h > 480) ? (h - 480) / 2 : 0;
        acc  = skip * step;
        top  = (h < 480) ? (480 - h) / 2 : 0;
        vis  = (h < 480) ? h : 480;

        check($sformatf("h%0d ready_idle", h), 32'(ready), 1);
        height = 10'(h);
        side   = s;
        col    = c;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check($sformatf("h%0d ready_drop", h), 32'(ready), 0);
        check($sformatf("h%0d done_clear", h), 32'(done), 0);

        for (int i = 1; i <= 29; i++) begin
            if (disturb && i == 5) begin
                start  = 1'b1;
                height = 10'd1;
                side   = ~s;
                col    = ~c;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check($sformatf("h%0d busy_before_run", h), 32'(ready), 0);

        adv = 1'b1;
        for (int y = 0; y < 480; y++) begin
            exp_act = (h != 0) && (y >= top) && (y < top + vis);
            exp_row = exp_act ? ((acc >> 12) & 63) : 0;
            check($sformatf("h%0d y%0d wall_active", h, y), 32'(wall_active), 32'(exp_act));
            check($sformatf("h%0d y%0d tex_row", h, y), 32'(tex_row), 32'(exp_row));
            check($sformatf("h%0d y%0d tex_side", h, y), 32'(tex_side), 32'(s));
            check($sformatf("h%0d y%0d tex_col", h, y), 32'(tex_col), 32'(c));
            check($sformatf("h%0d y%0d ready", h, y), 32'(ready), 0);
            check($sformatf("h%0d y%0d done", h, y), 32'(done), 0);
            for (int k = 0; k < 24; k++) begin
                if (vecs[k].h == h && vecs[k].y == y) begin
                    check($sformatf("vec h%0d y%0d act", h, y), 32'(wall_active), 32'(vecs[k].act));
                    check($sformatf("vec h%0d y%0d row", h, y), 32'(tex_row), 32'(vecs[k].row));
                end
            end
            if (disturb && y == 100) begin
                start = 1'b1;
                col   = ~c;
                side  = ~s;
            end else begin
                start = 1'b0;
            end
            tick();
            if (exp_act) acc += step;
        end
        adv   = 1'b0;
        start = 1'b0;
        check($sformatf("h%0d done_pulse", h), 32'(done), 1);
        check($sformatf("h%0d ready_back", h), 32'(ready), 1);
        check($sformatf("h%0d inactive_after", h), 32'(wall_active), 0);
        check($sformatf("h%0d col_hold", h), 32'(tex_col), 32'(c));
    endtask

    initial begin
        cmds[0] = '{64,  1'b1, 6'd5};
        cmds[1] = '{128, 1'b0, 6'd33};
        cmds[2] = '{960, 1'b1, 6'd63};
        cmds[3] = '{0,   1'b0, 6'd0};
        cmds[4] = '{1,   1'b1, 6'd12};

        vecs[0]  = '{64,  207, 1'b0, 0};
        vecs[1]  = '{64,  208, 1'b1, 0};
        vecs[2]  = '{64,  209, 1'b1, 1};
        vecs[3]  = '{64,  240, 1'b1, 32};
        vecs[4]  = '{64,  271, 1'b1, 63};
        vecs[5]  = '{64,  272, 1'b0, 0};
        vecs[6]  = '{128, 175, 1'b0, 0};
        vecs[7]  = '{128, 176, 1'b1, 0};
        vecs[8]  = '{128, 177, 1'b1, 0};
        vecs[9]  = '{128, 178, 1'b1, 1};
        vecs[10] = '{128, 303, 1'b1, 63};
        vecs[11] = '{128, 304, 1'b0, 0};
        vecs[12] = '{960, 0,   1'b1, 15};
        vecs[13] = '{960, 1,   1'b1, 16};
        vecs[14] = '{960, 240, 1'b1, 31};
        vecs[15] = '{960, 479, 1'b1, 47};
        vecs[16] = '{0,   0,   1'b0, 0};
        vecs[17] = '{0,   240, 1'b0, 0};
        vecs[18] = '{0,   479, 1'b0, 0};
        vecs[19] = '{1,   238, 1'b0, 0};
        vecs[20] = '{1,   239, 1'b1, 0};
        vecs[21] = '{1,   240, 1'b0, 0};
        vecs[22] = '{1,   0,   1'b0, 0};
        vecs[23] = '{1,   479, 1'b0, 0};

        reset_n = 1'b0;
        start   = 1'b0;
        adv     = 1'b0;
        height  = '0;
        side    = 1'b0;
        col     = '0;
        tick();
        tick();
        check("rst ready", 32'(ready), 1);
        check("rst done", 32'(done), 0);
        check("rst wall_active", 32'(wall_active), 0);
        check("rst tex_side", 32'(tex_side), 0);
        check("rst tex_col", 32'(tex_col), 0);
        check("rst tex_row", 32'(tex_row), 0);
        reset_n = 1'b1;
        tick();

        // adv while idle must not disturb anything
        adv = 1'b1;
        repeat (3) tick();
        adv = 1'b0;
        check("idle_adv ready", 32'(ready), 1);
        check("idle_adv done", 32'(done), 0);

        // back-to-back commands: each start lands in the done cycle
        for (int k = 0; k < 5; k++) begin
            run_cmd(cmds[k].h, cmds[k].s, cmds[k].c, 1'b0);
        end

        run_cmd(64, 1'b0, 6'd10, 1'b1);

        // asynchronous reset in the middle of the multiply phase
        height = 10'd64;
        side   = 1'b1;
        col    = 6'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (24) tick();
        reset_n = 1'b0;
        #1;
        check("midreset ready", 32'(ready), 1);
        check("midreset wall_active", 32'(wall_active), 0);
        check("midreset tex_row", 32'(tex_row), 0);
        check("midreset tex_col", 32'(tex_col), 0);
        check("midreset tex_side", 32'(tex_side), 0);
        check("midreset done", 32'(done), 0);
        tick();
        reset_n = 1'b1;
        tick();
        run_cmd(64, 1'b1, 6'd5, 1'b0);

        tick();
        check("final done_one_cycle", 32'(done), 0);
        check("final ready", 32'(ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
